// File: rtl/arbiter_4ch_rr.sv
`default_nettype none
// ============================================================================
// Module      : arbiter_4ch_rr
// Description : Four-channel round-robin arbiter. It feeds a 2-to-4 decoder
//               with {a,b} as the granted index and en as the grant-valid
//               enable. Grants are break-before-make: en drops for at least
//               one cycle between any two grants.
// Parameters  : HOLD_MAX - maximum grant length in cycles (2..31), used only
//                          when ARB_TIMEOUT_EN is defined
//               CNT_W    - hold-counter width, 2**CNT_W > HOLD_MAX
// Ports       : clk     in   clock, rising edge
//               rst_n   in   asynchronous active-low reset
//               req     in   [3:0] per-channel request, held while in use
//               done    in   grantee releases the grant (GRANT only)
//               a       out  granted index MSB
//               b       out  granted index LSB
//               en      out  grant valid
//               timeout out  one-cycle pulse after a forced release
// Options     : `define ARB_TIMEOUT_EN to build the hold counter and forced
//               release; otherwise timeout is tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module arbiter_4ch_rr #(
    parameter int HOLD_MAX = 16,
    parameter int CNT_W    = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       done,
    output logic       a,
    output logic       b,
    output logic       en,
    output logic       timeout
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     r_state;
    logic [1:0] r_ptr;
    logic       r_a;
    logic       r_b;
    logic       r_en;

    logic       w_found;
    logic [1:0] w_sel;
    logic [1:0] w_cand;
    logic [1:0] w_idx;
    logic       w_rel_user;
    logic       w_release;

    // Rotating priority scan: first requester at ptr, ptr+1, ... (mod 4).
    always_comb begin
        w_found = 1'b0;
        w_sel   = r_ptr;
        w_cand  = r_ptr;
        for (int k = 0; k < 4; k++) begin
            w_cand = r_ptr + 2'(k);
            if (!w_found && req[w_cand]) begin
                w_found = 1'b1;
                w_sel   = w_cand;
            end
        end
    end

    assign w_idx      = {r_a, r_b};
    assign w_rel_user = done | ~req[w_idx];

`ifdef ARB_TIMEOUT_EN
    logic [CNT_W-1:0] r_cnt;
    logic             r_timeout;
    logic             w_rel_to;

    // A forced release only counts when no user release applies at that edge.
    assign w_rel_to  = (r_cnt == CNT_W'(HOLD_MAX)) & ~w_rel_user;
    assign w_release = w_rel_user | w_rel_to;
    assign timeout   = r_timeout;
`else
    logic [CNT_W-1:0] unused_hold;

    assign unused_hold = CNT_W'(HOLD_MAX);
    assign w_release   = w_rel_user;
    assign timeout     = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_ptr     <= 2'd0;
            r_a       <= 1'b0;
            r_b       <= 1'b0;
            r_en      <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            r_cnt     <= '0;
            r_timeout <= 1'b0;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
            // Pulse lasts only the first IDLE cycle after a forced release.
            r_timeout <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    // {a,b} keep the last index while nobody requests.
                    if (w_found) begin
                        {r_a, r_b} <= w_sel;
                        r_en       <= 1'b1;
                        r_state    <= GRANT;
`ifdef ARB_TIMEOUT_EN
                        r_cnt      <= CNT_W'(1);
`endif
                    end
                end
                GRANT: begin
                    // Other channels' requests are not looked at here.
                    if (w_release) begin
                        r_en    <= 1'b0;
                        r_ptr   <= w_idx + 2'd1;
                        r_state <= IDLE;
`ifdef ARB_TIMEOUT_EN
                        r_cnt     <= '0;
                        r_timeout <= w_rel_to;
`endif
                    end else begin
`ifdef ARB_TIMEOUT_EN
                        r_cnt <= r_cnt + CNT_W'(1);
`endif
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_en    <= 1'b0;
                end
            endcase
        end
    end

    assign a  = r_a;
    assign b  = r_b;
    assign en = r_en;

endmodule
`default_nettype wire

// File: tb/tb_arbiter_4ch_rr.sv
`default_nettype none
// ============================================================================
// Module      : tb_arbiter_4ch_rr
// Description : Self-checking bench for arbiter_4ch_rr. Each step drives
//               req/done on the falling edge, queues the expected
//               {en,a,b,timeout} for the next rising edge, then pops and
//               compares it just after that edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arbiter_4ch_rr;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       done;
    logic       a;
    logic       b;
    logic       en;
    logic       timeout;

    int         total;
    int         bad;
    logic [3:0] sb[$];

    arbiter_4ch_rr #(
        .HOLD_MAX (4),
        .CNT_W    (5)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .done    (done),
        .a       (a),
        .b       (b),
        .en      (en),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got {en,a,b,to}=%b exp=%b", tag, got, exp);
        end
    endtask

    // Drive one cycle of stimulus and check the outputs after the next edge.
    task automatic step(input logic [3:0] r, input logic d, input logic [3:0] exp, input string tag);
        @(negedge clk);
        req  = r;
        done = d;
        sb.push_back(exp);
        @(posedge clk);
        #1;
        chk(tag, {en, a, b, timeout}, sb.pop_front());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        req   = 4'b1111;
        done  = 1'b0;

        // Reset held with all channels requesting.
        repeat (3) @(posedge clk);
        #1;
        chk("reset", {en, a, b, timeout}, 4'b0000);
        rst_n = 1'b1;

        // Round robin, done held high (also ignored in IDLE).
        step(4'b1111, 1'b1, 4'b1000, "rr_g0");
        step(4'b1111, 1'b1, 4'b0000, "rr_r0");
        step(4'b1111, 1'b1, 4'b1010, "rr_g1");
        step(4'b1111, 1'b1, 4'b0010, "rr_r1");
        step(4'b1111, 1'b1, 4'b1100, "rr_g2");
        step(4'b1111, 1'b1, 4'b0100, "rr_r2");
        step(4'b1111, 1'b1, 4'b1110, "rr_g3");
        step(4'b1111, 1'b1, 4'b0110, "rr_r3");
        step(4'b1111, 1'b1, 4'b1000, "rr_g0b");
        step(4'b1111, 1'b1, 4'b0000, "rr_r0b");
        step(4'b0000, 1'b0, 4'b0000, "idle_hold");

        // Single requester, done on 3rd grant cycle, then re-grant after gap.
        step(4'b0100, 1'b0, 4'b1100, "single_c1");
        step(4'b0100, 1'b0, 4'b1100, "single_c2");
        step(4'b0100, 1'b0, 4'b1100, "single_c3");
        step(4'b0100, 1'b1, 4'b0100, "single_rel");
        step(4'b0100, 1'b0, 4'b1100, "single_regrant");
        step(4'b0000, 1'b0, 4'b0100, "single_drop");

        // Channel 3 granted, other request ignored, req[3] drop, ptr wrap.
        step(4'b1001, 1'b0, 4'b1110, "drop_g3");
        step(4'b1001, 1'b0, 4'b1110, "drop_hold3");
        step(4'b0001, 1'b0, 4'b0110, "drop_rel3");
        step(4'b1001, 1'b0, 4'b1000, "wrap_g0");
        step(4'b0000, 1'b0, 4'b0000, "wrap_rel0");

        // Asynchronous reset during a channel-2 grant.
        step(4'b0100, 1'b0, 4'b1100, "mid_g2");
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async", {en, a, b, timeout}, 4'b0000);
        req   = 4'b0110;
        rst_n = 1'b1;
        step(4'b0110, 1'b0, 4'b1010, "post_rst_g1");
        step(4'b0110, 1'b1, 4'b0010, "post_rst_rel");

`ifdef ARB_TIMEOUT_EN
        // HOLD_MAX=4: forced release after 4 grant cycles.
        for (int i = 0; i < 4; i++)
            step(4'b0010, 1'b0, 4'b1010, "to_hold");
        step(4'b0010, 1'b0, 4'b0011, "to_pulse");
        step(4'b0010, 1'b0, 4'b1010, "to_regrant");
        for (int i = 0; i < 3; i++)
            step(4'b0010, 1'b0, 4'b1010, "to2_hold");
        step(4'b0010, 1'b1, 4'b0010, "to2_done");
        step(4'b0000, 1'b0, 4'b0010, "to2_nopulse");
`else
        // No timeout: grant held as long as the request stays up.
        for (int i = 0; i < 20; i++)
            step(4'b0010, 1'b0, 4'b1010, "long_hold");
        step(4'b0000, 1'b0, 4'b0010, "long_drop");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/arbiter_4ch_rr.md
# arbiter_4ch_rr

Four-channel round-robin arbiter that sits directly upstream of the 2-to-4 decoder. It grants one of four requesters at a time and presents the granted index as a 2-bit select plus an enable: `a` is the index MSB, `b` is the LSB, and `en` means the grant is valid. These drive the decoder's `a`, `b`, `en` inputs, so the decoder's one-hot output is the grant vector. Grants are break-before-make: `en` is low for at least one cycle between any two grants, so decoder outputs never overlap.

## Interface
- `HOLD_MAX`, default 16: maximum cycles a grant is held before a forced release. Range 2..31. Used only with `ARB_TIMEOUT_EN`.
- `CNT_W`, default 5: hold-counter width. Must satisfy 2^CNT_W > HOLD_MAX.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `req`  in  4  request per channel; `req[i]` is held high while channel i wants or uses the grant.
- `done`  in  1  the current grantee releases the grant; sampled only in GRANT.
- `a`  out  1  granted index, MSB.
- `b`  out  1  granted index, LSB.
- `en`  out  1  grant valid; the `{a,b}` select is meaningful only while this is high.
- `timeout`  out  1  one-cycle pulse when a grant is forcibly released.

## Operation
- All outputs are registered.
- Reset values: `a`=0, `b`=0, `en`=0, `timeout`=0. Internal state is IDLE, priority pointer `ptr`=0, hold counter=0.
- **IDLE** (`en`=0)
  - If `req`≠0, select the first set bit scanning `ptr`, `ptr`+1, … mod 4.
  - At the next edge: load `{a,b}` with the selected index, set `en`=1, move to GRANT.
  - If `req`=0, stay in IDLE and keep `{a,b}` unchanged.
- **GRANT** (`en`=1, index `idx`={a,b})
  - Release at an edge if `done`=1, or `req[idx]`=0, or a timeout fires (see Configuration).
  - On release: `en`=0, `ptr`=(`idx`+1) mod 4 (2-bit wrap, 3→0), go to IDLE. `{a,b}` keep the last index.
  - Requests from other channels arriving during GRANT have no effect until IDLE.
- IDLE always lasts at least one cycle after a release.
  - If the released channel still requests and no other channel does, it is re-granted after that single-cycle gap.
- `done` seen in IDLE is ignored.
- If `done` and a timeout coincide, the release counts as `done` and `timeout` stays 0.
- Reset asserted mid-grant: `en` and `timeout` clear immediately (asynchronously) and `ptr` returns to 0.

## Timing
- `req` sampled high at IDLE edge k → `en`=1 with a valid index from edge k onward (1-cycle latency).
- Release condition sampled at edge m → `en`=0 from edge m.
- Minimum grant length is 1 cycle; the hold counter reads 1 during the first grant cycle.
- Worst-case wait with all four channels requesting and each held for H cycles: 3·(H+1) cycles.
- `timeout` is high for exactly the first IDLE cycle after a forced release.

## Configuration
- `ARB_TIMEOUT_EN` defined:
  - A CNT_W-bit counter runs in GRANT.
  - At the edge where counter==`HOLD_MAX` and no other release applies, the grant is force-released and `timeout` pulses.
  - `en` is therefore held for at most `HOLD_MAX` cycles.
- `ARB_TIMEOUT_EN` undefined:
  - No counter is built and `timeout` is tied to 0.
  - A grant is held until `done` or until the grantee's `req` drops.

## Test plan
- Reset check: hold `rst_n`=0 with `req`=4'b1111 → `a`=0, `b`=0, `en`=0, `timeout`=0; release reset → `en`=1, `{a,b}`=00 one cycle later.
- Single requester: `req`=4'b0100, `done` pulsed on the 3rd grant cycle → `{a,b}`=10, `en`=1 for 3 cycles, then `en`=0.
- Round-robin: `req`=4'b1111 with `done` pulsed each grant cycle → grant sequence 00,01,10,11,00, each grant separated by one `en`=0 cycle.
- Drop release: channel 3 granted, `req[3]` falls → `en`=0 at the next edge; `ptr` wraps so `req`=4'b1001 next grants channel 0.
- Timeout (`ARB_TIMEOUT_EN`, `HOLD_MAX`=4): `req`=4'b0010 held, no `done` → `en` high for exactly 4 cycles, then `timeout`=1 for 1 cycle, then channel 1 re-granted. Repeat with `done` on the 4th cycle → `timeout` stays 0.
- Reset mid-grant: assert `rst_n`=0 between clock edges during a channel-2 grant → `en`=0 immediately; after reset, `req`=4'b0110 grants channel 1 (`ptr`=0).
